// File: rtl/fp16_pkg.sv
// ---------------------------------------------------------------------------
// fp16_pkg
// Shared definitions for the binary16 arithmetic unit: format constants,
// operation codes, the decoded-operand record and the helpers that decode a
// raw binary16 word and pack a normalized result back into one.
//
// Format: sign[15], exponent[14:10] (bias 15), fraction[9:0], hidden 1 when
// the exponent is non-zero. Exponent 0 is always treated as a signed zero.
// ---------------------------------------------------------------------------
package fp16_pkg;

  localparam logic signed [7:0] FP16_BIAS    = 8'sd15;
  localparam logic signed [7:0] FP16_EXP_MAX = 8'sd31;
  localparam logic [15:0]       FP16_QNAN    = 16'h7E00;
  localparam logic [15:0]       FP16_INF     = 16'h7C00;

  // Width of a significand including the hidden bit.
  localparam int FP16_SIG_W = 11;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIV  = 2'b10,
    OP_RSVD = 2'b11
  } fp16_op_e;

  // Decoded operand: sig carries the hidden bit, and is zero for a flushed
  // (exponent 0) input.
  typedef struct packed {
    logic                  sign;
    logic [4:0]            exp;
    logic [FP16_SIG_W-1:0] sig;
  } fp16_unpacked_t;

  // One operation's outcome before it reaches the output register.
  typedef struct packed {
    logic        exc;
    logic [15:0] value;
  } fp16_result_t;

  function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] raw);
    fp16_unpacked_t u;
    u.sign = raw[15];
    u.exp  = raw[14:10];
    // Subnormals are flushed: no hidden bit and no fraction survive.
    u.sig  = (raw[14:10] == 5'd0) ? '0 : {1'b1, raw[9:0]};
    return u;
  endfunction

  // Inf or NaN operand.
  function automatic logic fp16_is_special(input fp16_unpacked_t u);
    return &u.exp;
  endfunction

  function automatic logic fp16_is_zero(input fp16_unpacked_t u);
    return (u.exp == 5'd0);
  endfunction

  // Widen a biased exponent so sums and differences can go negative.
  function automatic logic signed [7:0] fp16_exp_ext(input logic [4:0] e);
    return $signed({3'b000, e});
  endfunction

  // Pack an already normalized result, saturating to signed Inf on
  // overflow (flagged) and flushing to signed zero on underflow (silent).
  function automatic fp16_result_t fp16_pack(input logic               sign,
                                             input logic signed [7:0] exp,
                                             input logic [9:0]        frac);
    fp16_result_t r;
    if (exp >= FP16_EXP_MAX) begin
      r.exc   = 1'b1;
      r.value = {sign, FP16_INF[14:0]};
    end else if (exp <= 8'sd0) begin
      r.exc   = 1'b0;
      r.value = {sign, 15'h0000};
    end else begin
      r.exc   = 1'b0;
      r.value = {sign, exp[4:0], frac};
    end
    return r;
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// ---------------------------------------------------------------------------
// fp16_lzc
// Leading-zero count of a 12-bit significand, used to renormalize the
// result of an effective subtraction.
//
// Ports:
//   sig_i    12-bit value to scan (MSB first)
//   count_o  number of zeros above the most significant 1; 12 when all zero
// ---------------------------------------------------------------------------
module fp16_lzc
  import fp16_pkg::*;
(
  input  logic [FP16_SIG_W:0] sig_i,
  output logic [3:0]          count_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    count_o = 4'd12;
    // Scanning upward lets the highest set bit overwrite the lower ones.
    for (int i = 0; i <= FP16_SIG_W; i++) begin
      if (sig_i[i]) begin
        count_o = 4'(FP16_SIG_W - i);
      end
    end
  end

endmodule

// File: rtl/fp16_arith_unit.sv
// ---------------------------------------------------------------------------
// fp16_arith_unit
// Registered binary16 add / multiply / divide. One operation is accepted per
// cycle and its result appears one cycle later with a single-cycle valid
// pulse. All rounding is truncation; subnormals are flushed to signed zero.
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Reset      asynchronous, active-high reset
//   i_Valid      operation request this cycle
//   i_Op         00 add, 01 multiply, 10 divide, 11 reserved
//   i_OperandA   addend / factor / dividend
//   i_OperandB   addend / factor / divisor
//   o_Result     registered binary16 result (holds when no request)
//   o_Valid      result valid, one cycle after the request
//   o_Exception  registered exception flag, qualified by o_Valid
// ---------------------------------------------------------------------------
module fp16_arith_unit
  import fp16_pkg::*;
(
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Valid,
  input  logic [1:0]  i_Op,
  input  logic [15:0] i_OperandA,
  input  logic [15:0] i_OperandB,
  output logic [15:0] o_Result,
  output logic        o_Valid,
  output logic        o_Exception
);

  fp16_unpacked_t ua;
  fp16_unpacked_t ub;
  fp16_op_e       op;
  logic           prod_sign;

  assign ua        = fp16_unpack(i_OperandA);
  assign ub        = fp16_unpack(i_OperandB);
  assign op        = fp16_op_e'(i_Op);
  assign prod_sign = ua.sign ^ ub.sign;

  // -------------------------------------------------------------------------
  // Add / subtract
  // -------------------------------------------------------------------------
  logic           a_ge_b;
  fp16_unpacked_t big_op;
  fp16_unpacked_t sml_op;
  logic [4:0]     exp_diff;
  logic [10:0]    sml_shifted;
  logic [11:0]    mag_sum;
  logic [10:0]    mag_diff;
  logic [3:0]     lead_zeros;
  logic [3:0]     norm_shift;
  fp16_result_t   add_res;

  // Exponent sits above significand, so one unsigned compare orders the
  // magnitudes; flushed zeros (exp 0, sig 0) sort below everything.
  assign a_ge_b = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
  assign big_op = a_ge_b ? ua : ub;
  assign sml_op = a_ge_b ? ub : ua;

  assign exp_diff    = big_op.exp - sml_op.exp;
  // Alignment shift discards the bits that fall off; no guard or sticky.
  assign sml_shifted = (exp_diff > 5'd11) ? '0 : (sml_op.sig >> exp_diff);
  assign mag_sum     = {1'b0, big_op.sig} + {1'b0, sml_shifted};
  assign mag_diff    = big_op.sig - sml_shifted;

  fp16_lzc u_lzc (
    .sig_i   ({1'b0, mag_diff}),
    .count_o (lead_zeros)
  );

  // The extra leading 0 fed to the counter is not part of the significand.
  assign norm_shift = lead_zeros - 4'd1;

  always_comb begin
    add_res = '0;
    if (big_op.sign == sml_op.sign) begin
      if (mag_sum == '0) begin
        add_res = '0;
      end else if (mag_sum[11]) begin
        // Carry out: shift right once and bump the exponent.
        add_res = fp16_pack(big_op.sign, fp16_exp_ext(big_op.exp) + 8'sd1,
                            mag_sum[10:1]);
      end else begin
        add_res = fp16_pack(big_op.sign, fp16_exp_ext(big_op.exp),
                            mag_sum[9:0]);
      end
    end else begin
      if (mag_diff == '0) begin
        // Exact cancellation is always +0, whatever the operand signs.
        add_res = '0;
      end else begin
        add_res = fp16_pack(big_op.sign,
                            fp16_exp_ext(big_op.exp) - $signed({4'b0000, norm_shift}),
                            10'(mag_diff << norm_shift));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Multiply
  // -------------------------------------------------------------------------
  logic [11:0]       prod_hi;
  logic signed [7:0] mul_exp;
  fp16_result_t      mul_res;

  // Product of two 1.x significands lies in [1, 4); only its top 12 bits
  // matter once the lower fraction bits are truncated.
  assign prod_hi = 12'(({11'b0, ua.sig} * {11'b0, ub.sig}) >> 10);
  assign mul_exp = fp16_exp_ext(ua.exp) + fp16_exp_ext(ub.exp) - FP16_BIAS
                 + $signed({7'b0000000, prod_hi[11]});
  assign mul_res = fp16_pack(prod_sign, mul_exp,
                             prod_hi[11] ? prod_hi[10:1] : prod_hi[9:0]);

  // -------------------------------------------------------------------------
  // Divide
  // -------------------------------------------------------------------------
  logic [10:0]       div_den;
  logic [11:0]       quot;
  logic signed [7:0] div_exp;
  fp16_result_t      div_res;

  // A zero divisor is steered to 1 so the divider never sees x/0; that case
  // is replaced by Inf/NaN before the quotient is used.
  assign div_den = (ub.sig == '0) ? 11'd1 : ub.sig;
  // Quotient of two 1.x significands lies in (0.5, 2): 12 bits, with the
  // integer bit at position 11.
  assign quot    = 12'({ua.sig, 11'b0} / {11'b0, div_den});
  assign div_exp = fp16_exp_ext(ua.exp) - fp16_exp_ext(ub.exp) + FP16_BIAS
                 - $signed({7'b0000000, ~quot[11]});
  assign div_res = fp16_pack(prod_sign, div_exp,
                             quot[11] ? quot[10:1] : quot[9:0]);

  // -------------------------------------------------------------------------
  // Operation select and special cases
  // -------------------------------------------------------------------------
  fp16_result_t op_res;

  always_comb begin
    op_res = '{exc: 1'b1, value: 16'h0000};
    if (op == OP_RSVD) begin
      op_res = '{exc: 1'b1, value: 16'h0000};
    end else if (fp16_is_special(ua) || fp16_is_special(ub)) begin
      op_res = '{exc: 1'b1, value: FP16_QNAN};
    end else begin
      unique case (op)
        OP_ADD: op_res = add_res;
        OP_MUL: begin
          if (fp16_is_zero(ua) || fp16_is_zero(ub)) begin
            op_res = '{exc: 1'b0, value: {prod_sign, 15'h0000}};
          end else begin
            op_res = mul_res;
          end
        end
        OP_DIV: begin
          if (fp16_is_zero(ub)) begin
            if (fp16_is_zero(ua)) begin
              op_res = '{exc: 1'b1, value: FP16_QNAN};
            end else begin
              op_res = '{exc: 1'b1, value: {prod_sign, FP16_INF[14:0]}};
            end
          end else if (fp16_is_zero(ua)) begin
            op_res = '{exc: 1'b0, value: {prod_sign, 15'h0000}};
          end else begin
            op_res = div_res;
          end
        end
        default: op_res = '{exc: 1'b1, value: 16'h0000};
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  logic [15:0] result_q, result_d;
  logic        exc_q,    exc_d;
  logic        valid_q,  valid_d;

  // Result and flag hold their last value between requests.
  always_comb begin
    result_d = result_q;
    exc_d    = exc_q;
    valid_d  = i_Valid;
    if (i_Valid) begin
      result_d = op_res.value;
      exc_d    = op_res.exc;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs as they were before the edge, independent of order.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      result_q <= 16'h0000;
      exc_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      exc_q    <= exc_d;
      valid_q  <= valid_d;
    end
  end

  assign o_Result    = result_q;
  assign o_Valid     = valid_q;
  assign o_Exception = exc_q;

endmodule

// File: tb/tb_fp16_arith_unit.sv
// ---------------------------------------------------------------------------
// tb_fp16_arith_unit
// Self-checking bench for fp16_arith_unit: a table of hand-derived vectors
// issued back to back, hold behaviour with i_Valid low, randomized operations
// against an integer reference model, and an asynchronous reset mid-stream.
// ---------------------------------------------------------------------------
module tb_fp16_arith_unit;

  logic        i_Clk;
  logic        i_Reset;
  logic        i_Valid;
  logic [1:0]  i_Op;
  logic [15:0] i_OperandA;
  logic [15:0] i_OperandB;
  logic [15:0] o_Result;
  logic        o_Valid;
  logic        o_Exception;

  int n_checks = 0;
  int n_fail   = 0;

  fp16_arith_unit dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Valid     (i_Valid),
    .i_Op        (i_Op),
    .i_OperandA  (i_OperandA),
    .i_OperandB  (i_OperandB),
    .o_Result    (o_Result),
    .o_Valid     (o_Valid),
    .o_Exception (o_Exception)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expect_out(input string name, input logic valid,
                            input logic [15:0] res, input logic exc);
    check({name, " valid"},  32'(o_Valid),     32'(valid));
    check({name, " result"}, 32'(o_Result),    32'(res));
    check({name, " exc"},    32'(o_Exception), 32'(exc));
  endtask

  task automatic drive(input logic valid, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    i_Valid    = valid;
    i_Op       = op;
    i_OperandA = a;
    i_OperandB = b;
  endtask

  task automatic add_vec(input string name, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic exc);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.exc = exc;
    vecs.push_back(v);
  endtask

  // -------------------------------------------------------------------------
  // Reference model: values as integer significands with a power-of-two
  // scale, normalized by plain loops. Returns {exception, result}.
  // -------------------------------------------------------------------------
  // m / 2^k is the significand, e the biased exponent.
  function automatic logic [16:0] pack_model(input logic s, input int m_in,
                                             input int k, input int e_in);
    int m;
    int e;
    m = m_in;
    e = e_in;
    while (m >= (2 << k)) begin m = m >> 1; e++; end
    while (m < (1 << k))  begin m = m << 1; e--; end
    if (e >= 31) return {1'b1, s, 15'h7C00};
    if (e <= 0)  return {1'b0, s, 15'h0000};
    return {1'b0, s, 5'(e), 10'((k >= 10) ? (m >> (k - 10)) : (m << (10 - k)))};
  endfunction

  function automatic logic [16:0] model(input logic [1:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    int   ea, eb, ma, mb, el, es, ml, ms, d, m;
    logic sa, sb, sl, ss;
    sa = a[15];
    sb = b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
    mb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
    if (op == 2'b11) return {1'b1, 16'h0000};
    if (ea == 31 || eb == 31) return {1'b1, 16'h7E00};
    case (op)
      2'b00: begin
        if (ea * 2048 + ma >= eb * 2048 + mb) begin
          sl = sa; el = ea; ml = ma; ss = sb; es = eb; ms = mb;
        end else begin
          sl = sb; el = eb; ml = mb; ss = sa; es = ea; ms = ma;
        end
        d = el - es;
        ms = (d > 11) ? 0 : (ms >> d);
        m = (sl == ss) ? (ml + ms) : (ml - ms);
        if (m == 0) return {1'b0, 16'h0000};
        return pack_model(sl, m, 10, el);
      end
      2'b01: begin
        if (ma == 0 || mb == 0) return {1'b0, sa ^ sb, 15'h0000};
        return pack_model(sa ^ sb, ma * mb, 20, ea + eb - 15);
      end
      default: begin
        if (mb == 0) begin
          if (ma == 0) return {1'b1, 16'h7E00};
          return {1'b1, sa ^ sb, 15'h7C00};
        end
        if (ma == 0) return {1'b0, sa ^ sb, 15'h0000};
        return pack_model(sa ^ sb, (ma << 11) / mb, 11, ea - eb + 15);
      end
    endcase
  endfunction

  // Mostly normal numbers, with occasional zero, subnormal, Inf and NaN.
  function automatic logic [15:0] rand_fp();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 9) < 8) v[14:10] = 5'($urandom_range(1, 30));
    return v;
  endfunction

  logic [16:0] last_exp;
  logic [16:0] exp_v;
  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;

  initial begin
    // Directed vectors with hand-derived results.
    add_vec("add 1+1",          2'b00, 16'h3C00, 16'h3C00, 16'h4000, 1'b0);
    add_vec("add 1-1",          2'b00, 16'h3C00, 16'hBC00, 16'h0000, 1'b0);
    add_vec("add 3-1",          2'b00, 16'h4200, 16'hBC00, 16'h4000, 1'b0);
    add_vec("mul -1*2",         2'b01, 16'hBC00, 16'h4000, 16'hC000, 1'b0);
    add_vec("div 3/2",          2'b10, 16'h4200, 16'h4000, 16'h3E00, 1'b0);
    add_vec("mul 1.5*2",        2'b01, 16'h3E00, 16'h4000, 16'h4200, 1'b0);
    add_vec("mul overflow",     2'b01, 16'h7BFF, 16'h4000, 16'h7C00, 1'b1);
    add_vec("div 1/0",          2'b10, 16'h3C00, 16'h0000, 16'h7C00, 1'b1);
    add_vec("div 0/0",          2'b10, 16'h0000, 16'h0000, 16'h7E00, 1'b1);
    add_vec("add inf",          2'b00, 16'h7C00, 16'h3C00, 16'h7E00, 1'b1);
    add_vec("reserved op",      2'b11, 16'h3C00, 16'h3C00, 16'h0000, 1'b1);
    add_vec("reserved op inf",  2'b11, 16'h7C00, 16'h7C00, 16'h0000, 1'b1);
    add_vec("add far apart",    2'b00, 16'h7000, 16'h3C00, 16'h7000, 1'b0);
    add_vec("add cancel",       2'b00, 16'h3C01, 16'hBC00, 16'h1400, 1'b0);
    add_vec("sub underflow",    2'b00, 16'h8401, 16'h0400, 16'h8000, 1'b0);
    add_vec("mul subnormal",    2'b01, 16'h0001, 16'h3C00, 16'h0000, 1'b0);
    add_vec("mul neg zero",     2'b01, 16'h8200, 16'h3C00, 16'h8000, 1'b0);
    add_vec("mul underflow",    2'b01, 16'h0400, 16'h0400, 16'h0000, 1'b0);
    add_vec("div zero num",     2'b10, 16'h8000, 16'h4000, 16'h8000, 1'b0);
    add_vec("div 1/1.5",        2'b10, 16'h3C00, 16'h3E00, 16'h3955, 1'b0);
    add_vec("div -1/-0",        2'b10, 16'hBC00, 16'h8000, 16'h7C00, 1'b1);
    add_vec("div overflow",     2'b10, 16'h7800, 16'h3400, 16'h7C00, 1'b1);

    // Reset state.
    i_Reset = 1'b1;
    drive(1'b0, 2'b00, 16'h0000, 16'h0000);
    #1;
    expect_out("reset state", 1'b0, 16'h0000, 1'b0);
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Reset = 1'b0;

    // Table vectors, one issue per cycle; each result checked one cycle on.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge i_Clk);
      expect_out(vecs[i].name, 1'b1, vecs[i].res, vecs[i].exc);
    end
    last_exp = {vecs[vecs.size()-1].exc, vecs[vecs.size()-1].res};

    // Idle cycles: no pulse, result and flag hold.
    drive(1'b0, 2'b00, 16'h3C00, 16'h3C00);
    for (int i = 0; i < 2; i++) begin
      @(negedge i_Clk);
      expect_out("idle hold", 1'b0, last_exp[15:0], last_exp[16]);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        drive(1'b0, 2'($urandom), rand_fp(), rand_fp());
        @(negedge i_Clk);
        expect_out("random idle", 1'b0, last_exp[15:0], last_exp[16]);
      end else begin
        r_op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r_a  = rand_fp();
        r_b  = rand_fp();
        // Near-cancelling pairs exercise the renormalization path.
        if ($urandom_range(0, 3) == 0) r_b = r_a ^ 16'h8000 ^ 16'($urandom_range(0, 3));
        exp_v = model(r_op, r_a, r_b);
        drive(1'b1, r_op, r_a, r_b);
        @(negedge i_Clk);
        if (o_Result !== exp_v[15:0] || o_Exception !== exp_v[16] || o_Valid !== 1'b1)
          $display("  random op=%0d a=0x%h b=0x%h", r_op, r_a, r_b);
        expect_out("random op", 1'b1, exp_v[15:0], exp_v[16]);
        last_exp = exp_v;
      end
    end

    // Asynchronous reset mid-cycle clears a freshly registered result.
    drive(1'b1, 2'b00, 16'h3C00, 16'h3C00);
    @(posedge i_Clk);
    #2;
    i_Reset = 1'b1;
    #1;
    expect_out("async reset", 1'b0, 16'h0000, 1'b0);

    // A request presented while reset is held is discarded.
    @(negedge i_Clk);
    drive(1'b1, 2'b01, 16'h3E00, 16'h4000);
    @(posedge i_Clk);
    #1;
    expect_out("held in reset", 1'b0, 16'h0000, 1'b0);
    @(negedge i_Clk);
    i_Reset = 1'b0;
    drive(1'b0, 2'b00, 16'h0000, 16'h0000);
    @(negedge i_Clk);
    expect_out("after reset idle", 1'b0, 16'h0000, 1'b0);

    // Normal operation resumes after reset.
    drive(1'b1, 2'b01, 16'h3E00, 16'h4000);
    @(negedge i_Clk);
    expect_out("after reset mul", 1'b1, 16'h4200, 1'b0);
    drive(1'b0, 2'b00, 16'h0000, 16'h0000);
    @(negedge i_Clk);
    expect_out("final idle", 1'b0, 16'h4200, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_arith_unit.md
Name: fp16_arith_unit

Overview:
Registered IEEE-754 binary16 (half-precision) arithmetic unit providing add, multiply and divide behind one operation select. It is the shared arithmetic primitive of the graphics pipeline, used for vertex scale/rotate/translate, camera-relative offset and perspective divide. One operation is accepted per cycle; the result and an exception flag appear one cycle later.

Parameters:
None.

Ports:
i_Clk  input  1  clock; all state updates on its rising edge
i_Reset  input  1  asynchronous, active-high reset
i_Valid  input  1  operation request this cycle
i_Op  input  2  operation: 00 add (A+B), 01 multiply (A*B), 10 divide (A/B), 11 reserved
i_OperandA  input  16  binary16 operand A (addend, factor or dividend)
i_OperandB  input  16  binary16 operand B (addend, factor or divisor)
o_Result  output  16  binary16 result, registered
o_Valid  output  1  result valid; single-cycle pulse
o_Exception  output  1  exception flag qualified by o_Valid, registered

Behaviour:
- Reset: asynchronous on i_Reset high. o_Result=16'h0000, o_Valid=0, o_Exception=0 immediately, held while reset is asserted.
- Latency: exactly 1 cycle. Inputs sampled at edge N with i_Valid=1 give o_Valid=1 with the result after edge N. Back-to-back issue every cycle is supported. There is no backpressure.
- i_Valid=0: o_Valid=0 at next edge; o_Result and o_Exception hold their previous values.
- Format: sign[15], exponent[14:10] with bias 15, fraction[9:0]. Hidden 1 when exponent is non-zero.
- Exponent 0 (zero or subnormal) inputs are treated as signed zero (flush). Subnormal results are flushed to signed zero with no exception.
- Exponent 31 (Inf/NaN) inputs: result 16'h7E00, exception=1.
- Rounding: truncation (toward zero) everywhere. There are no guard or sticky bits.
- Add: the operand with the smaller magnitude has its 11-bit significand right-shifted by the exponent difference. Bits shifted out are discarded; a difference above 11 leaves 0. Same signs: significands are added, with a 1-bit right normalize on carry. Different signs: the smaller is subtracted from the larger, the result takes the sign of the larger, and it is left-normalized by leading-zero count. An exact zero result is +0 (16'h0000).
- Multiply: sign = sA^sB. The 11x11 significand product (22 bits) is normalized by 0 or 1 position and truncated to 10 fraction bits. Exponent = eA+eB-15(+1). Either operand zero gives signed zero, no exception.
- Divide: sign = sA^sB. Quotient significand = (mA<<11)/mB (integer), normalized and truncated. Exponent = eA-eB+15(-1 if normalize).
  - Divisor zero, dividend non-zero: result is signed Inf (sign<<15 | 16'h7C00), exception=1.
  - 0/0: 16'h7E00, exception=1.
  - Zero dividend with non-zero divisor: signed zero, no exception.
- Overflow: a result exponent of 31 or more in any op gives signed Inf, exception=1.
- Underflow: a result exponent of 0 or less gives signed zero, exception=0.
- i_Op=11: o_Result=16'h0000, o_Exception=1.
- Reset mid-stream: an in-flight result is discarded and o_Valid=0.

Decomposition:
- Package fp16_pkg holds:
  - constants FP16_BIAS=15, FP16_EXP_MAX=31, FP16_QNAN=16'h7E00, FP16_INF=16'h7C00
  - op codes OP_ADD, OP_MUL, OP_DIV, OP_RSVD
  - a typedef for unpacked {sign, exp[4:0], sig[10:0]}
- One sub-module: fp16_lzc (leading-zero count on a 12-bit significand), used for add/sub renormalization.
- Add, multiply and divide datapaths are combinational inside fp16_arith_unit, with a shared output register stage.

Test Plan:
- Reset: assert i_Reset asynchronously mid-cycle -> o_Result=0x0000, o_Valid=0, o_Exception=0 immediately.
- Add:
  - 0x3C00+0x3C00 -> 0x4000.
  - 0x3C00+0xBC00 -> 0x0000.
  - 0x4200+0xBC00 -> 0x4000.
  - All with o_Valid one cycle after issue, exception=0.
- Multiply:
  - 0xBC00*0x4000 -> 0xC000.
  - 0x3E00*0x4000 -> 0x4200.
  - 0x7BFF*0x4000 -> 0x7C00 with exception=1.
- Divide:
  - 0x4200/0x4000 -> 0x3E00.
  - 0x3C00/0x0000 -> 0x7C00 with exception=1.
  - 0x0000/0x0000 -> 0x7E00 with exception=1.
- Special inputs: 0x7C00+0x3C00 -> 0x7E00 with exception=1. i_Op=11 -> 0x0000 with exception=1.
- Throughput: issue add, mul, div on consecutive cycles -> three consecutive o_Valid pulses with in-order results. i_Valid=0 afterwards -> o_Valid=0 and o_Result holds the last value.
